// File: rtl/i2c_master_txn_seq_pkg.sv
// Types and per-state command decode for the I2C register-transaction sequencer.
package i2c_master_txn_seq_pkg;

`include "i2c_master_defines.v"

  typedef enum logic [2:0] {
    ST_IDLE     = `I2C_ST_IDLE,
    ST_ADDR_W   = `I2C_ST_ADDR_W,
    ST_REG      = `I2C_ST_REG,
    ST_WDATA    = `I2C_ST_WDATA,
    ST_ADDR_R   = `I2C_ST_ADDR_R,
    ST_RDATA    = `I2C_ST_RDATA,
    ST_STOP_ERR = `I2C_ST_STOP_ERR,
    ST_RESP     = `I2C_ST_RESP
  } state_t;

  localparam logic [1:0] ERR_OK   = `I2C_ERR_OK;
  localparam logic [1:0] ERR_NACK = `I2C_ERR_NACK;
  localparam logic [1:0] ERR_AL   = `I2C_ERR_AL;

  typedef struct packed {
    logic       start;
    logic       stop;
    logic       read;
    logic       write;
    logic       tx_ack;
    logic [7:0] txr;
  } cmd_t;

  // Command word the byte controller must see while a state is waiting for I2C_done.
  function automatic cmd_t state_cmd(input state_t st, input logic [6:0] slv,
                                     input logic [7:0] regad, input logic [7:0] wdata);
    cmd_t c;
    c = '0;
    case (st)
      ST_ADDR_W: begin
        c.start = 1'b1;
        c.write = 1'b1;
        c.txr   = {slv, 1'b0};
      end
      ST_REG: begin
        c.write = 1'b1;
        c.txr   = regad;
      end
      ST_WDATA: begin
        c.write = 1'b1;
        c.stop  = 1'b1;
        c.txr   = wdata;
      end
      ST_ADDR_R: begin
        c.start = 1'b1;
        c.write = 1'b1;
        c.txr   = {slv, 1'b1};
      end
      ST_RDATA: begin
        c.read   = 1'b1;
        c.stop   = 1'b1;
        c.tx_ack = 1'b1;
      end
      ST_STOP_ERR: c.stop = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/i2c_master_defines.v
// Shared I2C master encodings: transaction-sequencer state codes and response error codes.
`ifndef I2C_MASTER_DEFINES_V
`define I2C_MASTER_DEFINES_V

`define I2C_ST_IDLE     3'd0
`define I2C_ST_ADDR_W   3'd1
`define I2C_ST_REG      3'd2
`define I2C_ST_WDATA    3'd3
`define I2C_ST_ADDR_R   3'd4
`define I2C_ST_RDATA    3'd5
`define I2C_ST_STOP_ERR 3'd6
`define I2C_ST_RESP     3'd7

`define I2C_ERR_OK      2'b00
`define I2C_ERR_NACK    2'b01
`define I2C_ERR_AL      2'b10

`endif

// File: rtl/i2c_master_txn_seq.sv
// Sequences one I2C register write or read through a byte controller and reports a one-cycle response.
// Optional address-NACK retry is built in when I2C_TXN_RETRY_EN is defined.
module i2c_master_txn_seq
  import i2c_master_txn_seq_pkg::*;
#(
  parameter int unsigned MAX_RETRY = 2
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Req_valid,
  output logic       Req_ready,
  input  logic       Req_rw,
  input  logic [6:0] Req_slv,
  input  logic [7:0] Req_reg,
  input  logic [7:0] Req_wdata,
  output logic       Rsp_valid,
  output logic [1:0] Rsp_err,
  output logic [7:0] Rsp_rdata,
  output logic       Start,
  output logic       Stop,
  output logic       Read,
  output logic       Write,
  output logic       Tx_ack,
  output logic [7:0] Txr,
  input  logic [7:0] Rxr,
  input  logic       I2C_done,
  input  logic       Rx_ack,
  input  logic       I2C_al,
  output logic       Busy
);

  state_t     state_q, state_d;
  cmd_t       cmd_q, cmd_d;
  logic [1:0] err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       rw_q;
  logic [6:0] slv_q;
  logic [7:0] regad_q, wdata_q;
  logic       accept;
  logic       do_retry;

  assign accept = Req_valid && (state_q == ST_IDLE);

`ifdef I2C_TXN_RETRY_EN
  localparam logic [1:0] RETRY_LIM = MAX_RETRY[1:0];

  logic [1:0] retry_q, retry_d;
  logic       addr_nack_q, addr_nack_d;

  // Only a NACK on the first address byte is worth retrying.
  assign do_retry = addr_nack_q && (retry_q < RETRY_LIM);

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      retry_q     <= 2'd0;
      addr_nack_q <= 1'b0;
    end else begin
      retry_q     <= retry_d;
      addr_nack_q <= addr_nack_d;
    end
  end
`else
  logic unused_max_retry;
  assign unused_max_retry = ^MAX_RETRY;
  assign do_retry         = 1'b0;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      err_q   <= ERR_OK;
      rdata_q <= 8'h00;
      rw_q    <= 1'b0;
      slv_q   <= 7'h00;
      regad_q <= 8'h00;
      wdata_q <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      if (accept) begin
        rw_q    <= Req_rw;
        slv_q   <= Req_slv;
        regad_q <= Req_reg;
        wdata_q <= Req_wdata;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef I2C_TXN_RETRY_EN
    retry_d     = retry_q;
    addr_nack_d = addr_nack_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_ADDR_W;
`ifdef I2C_TXN_RETRY_EN
          retry_d = 2'd0;
`endif
        end
      end
      ST_ADDR_W: if (I2C_done) state_d = Rx_ack ? ST_STOP_ERR : ST_REG;
      ST_REG: begin
        if (I2C_done) begin
          if (Rx_ack)    state_d = ST_STOP_ERR;
          else if (rw_q) state_d = ST_ADDR_R;
          else           state_d = ST_WDATA;
        end
      end
      ST_WDATA: begin
        if (I2C_done) begin
          state_d = ST_RESP;
          err_d   = Rx_ack ? ERR_NACK : ERR_OK;
          rdata_d = 8'h00;
        end
      end
      ST_ADDR_R: if (I2C_done) state_d = Rx_ack ? ST_STOP_ERR : ST_RDATA;
      ST_RDATA: begin
        if (I2C_done) begin
          state_d = ST_RESP;
          err_d   = ERR_OK;
          rdata_d = Rxr;
        end
      end
      ST_STOP_ERR: begin
        if (I2C_done) begin
          if (do_retry) begin
            state_d = ST_ADDR_W;
`ifdef I2C_TXN_RETRY_EN
            retry_d = retry_q + 2'd1;
`endif
          end else begin
            state_d = ST_RESP;
            err_d   = ERR_NACK;
            rdata_d = 8'h00;
          end
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Lost arbitration abandons the bus silently: no Stop, straight to the response.
    if (I2C_al && (state_q != ST_IDLE) && (state_q != ST_RESP)) begin
      state_d = ST_RESP;
      err_d   = ERR_AL;
      rdata_d = 8'h00;
    end

`ifdef I2C_TXN_RETRY_EN
    if ((state_d == ST_STOP_ERR) && (state_q != ST_STOP_ERR))
      addr_nack_d = (state_q == ST_ADDR_W);
`endif

    // Commands drop the cycle after any state change and reload one cycle later.
    cmd_d = (state_d == state_q) ? state_cmd(state_q, slv_q, regad_q, wdata_q) : '0;
  end

  assign Start     = cmd_q.start;
  assign Stop      = cmd_q.stop;
  assign Read      = cmd_q.read;
  assign Write     = cmd_q.write;
  assign Tx_ack    = cmd_q.tx_ack;
  assign Txr       = cmd_q.txr;
  assign Req_ready = (state_q == ST_IDLE);
  assign Busy      = ~Req_ready;
  assign Rsp_valid = (state_q == ST_RESP);
  assign Rsp_err   = err_q;
  assign Rsp_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_master_txn_seq.sv
// Directed bench for i2c_master_txn_seq: table of transactions against a simple byte-controller responder.
module tb_i2c_master_txn_seq;

  logic       Clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Req_valid = 1'b0;
  logic       Req_ready;
  logic       Req_rw = 1'b0;
  logic [6:0] Req_slv = 7'h00;
  logic [7:0] Req_reg = 8'h00;
  logic [7:0] Req_wdata = 8'h00;
  logic       Rsp_valid;
  logic [1:0] Rsp_err;
  logic [7:0] Rsp_rdata;
  logic       Start, Stop, Read, Write, Tx_ack;
  logic [7:0] Txr;
  logic [7:0] Rxr = 8'h00;
  logic       I2C_done = 1'b0;
  logic       Rx_ack = 1'b0;
  logic       I2C_al = 1'b0;
  logic       Busy;
  logic       cmd_act;

  int n_cmp = 0;
  int n_bad = 0;

  i2c_master_txn_seq #(.MAX_RETRY(2)) dut (
    .Clk(Clk), .Rst_n(Rst_n),
    .Req_valid(Req_valid), .Req_ready(Req_ready), .Req_rw(Req_rw),
    .Req_slv(Req_slv), .Req_reg(Req_reg), .Req_wdata(Req_wdata),
    .Rsp_valid(Rsp_valid), .Rsp_err(Rsp_err), .Rsp_rdata(Rsp_rdata),
    .Start(Start), .Stop(Stop), .Read(Read), .Write(Write), .Tx_ack(Tx_ack),
    .Txr(Txr), .Rxr(Rxr), .I2C_done(I2C_done), .Rx_ack(Rx_ack),
    .I2C_al(I2C_al), .Busy(Busy)
  );

  initial forever #5 Clk = ~Clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  assign cmd_act = Start | Stop | Read | Write;

  typedef struct {
    logic             rw;
    logic [6:0]       slv;
    logic [7:0]       rg;
    logic [7:0]       wd;
    logic [7:0]       rxr;
    logic [7:0]       nack_mask;
    logic [7:0]       al_mask;
    bit               spam;
    int               n_exp;
    logic [7:0][12:0] exp_cmd;
    logic [1:0]       exp_err;
    logic [7:0]       exp_rdata;
  } vec_t;

  localparam int NV = 8;
  vec_t vecs[NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // {Start, Stop, Read, Write, Tx_ack, Txr}
  function automatic logic [12:0] C(input bit s, input bit p, input bit r, input bit w,
                                    input bit a, input logic [7:0] t);
    return {s, p, r, w, a, t};
  endfunction

  task automatic mk(input int i, input logic rw, input logic [6:0] slv, input logic [7:0] rg,
                    input logic [7:0] wd, input logic [7:0] rxr, input logic [7:0] nack,
                    input logic [7:0] al, input bit spam, input logic [1:0] err,
                    input logic [7:0] rdata);
    vecs[i].rw = rw;   vecs[i].slv = slv; vecs[i].rg = rg; vecs[i].wd = wd;
    vecs[i].rxr = rxr; vecs[i].nack_mask = nack; vecs[i].al_mask = al;
    vecs[i].spam = spam; vecs[i].exp_err = err; vecs[i].exp_rdata = rdata;
    vecs[i].n_exp = 0; vecs[i].exp_cmd = '0;
  endtask

  task automatic push(input int i, input logic [12:0] c);
    vecs[i].exp_cmd[vecs[i].n_exp] = c;
    vecs[i].n_exp++;
  endtask

  task automatic run_txn(input int i);
    vec_t v;
    logic [12:0] got[8];
    int ncmd, age, cyc;
    bit seen;
    v = vecs[i];
    ncmd = 0; age = 0; cyc = 0; seen = 0;
    for (int k = 0; k < 8; k++) got[k] = '0;
    @(negedge Clk);
    Req_rw = v.rw; Req_slv = v.slv; Req_reg = v.rg; Req_wdata = v.wd; Req_valid = 1'b1;
    Rxr = v.rxr;
    @(negedge Clk);
    check($sformatf("v%0d_busy_after_accept", i), Busy, 1);
    if (v.spam) begin
      Req_rw = ~v.rw; Req_slv = 7'h11; Req_reg = 8'hEE; Req_wdata = 8'hDD;
    end else begin
      Req_valid = 1'b0;
    end
    while (!seen && cyc < 200) begin
      @(negedge Clk);
      cyc++;
      I2C_done = 1'b0; I2C_al = 1'b0; Rx_ack = 1'b0;
      if (Rsp_valid) begin
        seen = 1;
        Req_valid = 1'b0;
      end else if (cmd_act) begin
        if (age == 0 && ncmd < 8) got[ncmd] = {Start, Stop, Read, Write, Tx_ack, Txr};
        age++;
        if (age == 2) begin
          I2C_done = 1'b1;
          Rx_ack   = (ncmd < 8) ? v.nack_mask[ncmd] : 1'b0;
          I2C_al   = (ncmd < 8) ? v.al_mask[ncmd] : 1'b0;
          ncmd++;
          age = 0;
        end
      end else begin
        age = 0;
      end
    end
    Req_valid = 1'b0;
    check($sformatf("v%0d_rsp_seen", i), seen, 1);
    if (seen) begin
      check($sformatf("v%0d_ready_in_resp", i), Req_ready, 0);
      check($sformatf("v%0d_err", i), Rsp_err, v.exp_err);
      check($sformatf("v%0d_rdata", i), Rsp_rdata, v.exp_rdata);
      check($sformatf("v%0d_ncmd", i), ncmd, v.n_exp);
      for (int k = 0; k < v.n_exp && k < 8; k++)
        check($sformatf("v%0d_cmd%0d", i, k), got[k], v.exp_cmd[k]);
      @(negedge Clk);
      check($sformatf("v%0d_pulse_one", i), {Rsp_valid, Req_ready}, 2'b01);
      check($sformatf("v%0d_rdata_hold", i), {Rsp_err, Rsp_rdata}, {v.exp_err, v.exp_rdata});
      @(negedge Clk);
      check($sformatf("v%0d_idle_after", i), Busy, 0);
    end
  endtask

  task automatic serve_one(input logic ack, input string nm);
    int n;
    n = 0;
    while (!cmd_act && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check({nm, "_cmd_seen"}, cmd_act, 1);
    @(negedge Clk);
    I2C_done = 1'b1; Rx_ack = ack;
    @(negedge Clk);
    I2C_done = 1'b0; Rx_ack = 1'b0;
  endtask

  initial begin
    int n;
    mk(0, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h00, 0, 2'b00, 8'h00);
    push(0, C(1,0,0,1,0,8'hA0)); push(0, C(0,0,0,1,0,8'h10)); push(0, C(0,1,0,1,0,8'hA5));
    mk(1, 1'b1, 7'h50, 8'h20, 8'h00, 8'h3C, 8'h00, 8'h00, 1, 2'b00, 8'h3C);
    push(1, C(1,0,0,1,0,8'hA0)); push(1, C(0,0,0,1,0,8'h20)); push(1, C(1,0,0,1,0,8'hA1));
    push(1, C(0,1,1,0,1,8'h00));
    mk(2, 1'b0, 7'h50, 8'h33, 8'h77, 8'h00, 8'h02, 8'h00, 0, 2'b01, 8'h00);
    push(2, C(1,0,0,1,0,8'hA0)); push(2, C(0,0,0,1,0,8'h33)); push(2, C(0,1,0,0,0,8'h00));
    mk(3, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h00, 8'h04, 0, 2'b10, 8'h00);
    push(3, C(1,0,0,1,0,8'hA0)); push(3, C(0,0,0,1,0,8'h10)); push(3, C(0,1,0,1,0,8'hA5));
    mk(4, 1'b0, 7'h12, 8'h34, 8'h56, 8'h00, 8'h04, 8'h00, 0, 2'b01, 8'h00);
    push(4, C(1,0,0,1,0,8'h24)); push(4, C(0,0,0,1,0,8'h34)); push(4, C(0,1,0,1,0,8'h56));
    mk(5, 1'b1, 7'h7F, 8'h01, 8'h00, 8'h99, 8'h04, 8'h00, 0, 2'b01, 8'h00);
    push(5, C(1,0,0,1,0,8'hFE)); push(5, C(0,0,0,1,0,8'h01)); push(5, C(1,0,0,1,0,8'hFF));
    push(5, C(0,1,0,0,0,8'h00));
    mk(6, 1'b1, 7'h50, 8'h20, 8'h00, 8'h5A, 8'h00, 8'h01, 0, 2'b10, 8'h00);
    push(6, C(1,0,0,1,0,8'hA0));
`ifdef I2C_TXN_RETRY_EN
    mk(7, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h15, 8'h00, 0, 2'b01, 8'h00);
    for (int k = 0; k < 3; k++) begin
      push(7, C(1,0,0,1,0,8'hA0)); push(7, C(0,1,0,0,0,8'h00));
    end
`else
    mk(7, 1'b0, 7'h50, 8'h10, 8'hA5, 8'h00, 8'h01, 8'h00, 0, 2'b01, 8'h00);
    push(7, C(1,0,0,1,0,8'hA0)); push(7, C(0,1,0,0,0,8'h00));
`endif

    repeat (3) @(negedge Clk);
    check("reset_outputs",
          {Start, Stop, Read, Write, Tx_ack, Txr, Rsp_valid, Rsp_err, Rsp_rdata, Busy, Req_ready},
          26'd1);
    Rst_n = 1'b1;
    @(negedge Clk);

    for (int i = 0; i < NV; i++) run_txn(i);

    // I2C_done while idle must not disturb anything.
    @(negedge Clk);
    I2C_done = 1'b1; Rx_ack = 1'b1;
    @(negedge Clk);
    I2C_done = 1'b0; Rx_ack = 1'b0;
    @(negedge Clk);
    check("done_while_idle", {Busy, Rsp_valid, cmd_act, Txr}, 11'd0);

    // Reset asserted while the read-data byte is in flight.
    Req_rw = 1'b1; Req_slv = 7'h50; Req_reg = 8'h20; Req_wdata = 8'h00; Req_valid = 1'b1;
    Rxr = 8'h3C;
    @(negedge Clk);
    Req_valid = 1'b0;
    serve_one(1'b0, "rst_addr_w");
    serve_one(1'b0, "rst_reg");
    serve_one(1'b0, "rst_addr_r");
    n = 0;
    while (!Read && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("rst_rdata_reached", Read, 1);
    Rst_n = 1'b0;
    #1;
    check("reset_mid_rdata",
          {Start, Stop, Read, Write, Tx_ack, Txr, Rsp_valid, Rsp_err, Rsp_rdata, Busy, Req_ready},
          26'd1);
    @(negedge Clk);
    Rst_n = 1'b1;
    @(negedge Clk);
    Req_rw = 1'b0; Req_slv = 7'h50; Req_reg = 8'h10; Req_wdata = 8'hA5; Req_valid = 1'b1;
    check("ready_after_release", Req_ready, 1);
    @(negedge Clk);
    Req_valid = 1'b0;
    check("accept_first_cycle", Busy, 1);
    serve_one(1'b0, "post_addr_w");
    serve_one(1'b0, "post_reg");
    serve_one(1'b0, "post_wdata");
    n = 0;
    while (!Rsp_valid && n < 50) begin
      @(negedge Clk);
      n++;
    end
    check("post_reset_rsp", {Rsp_valid, Rsp_err, Rsp_rdata}, {1'b1, 2'b00, 8'h00});

    repeat (2) @(negedge Clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2c_master_txn_seq.md
I2C_MASTER_TXN_SEQ -- requirements
Module: i2c_master_txn_seq

Interface
REQ-001 The block SHALL have parameter MAX_RETRY, default 2, giving the number of address-NACK retries (used only with I2C_TXN_RETRY_EN).
REQ-002 The block SHALL have these ports, clock and reset first:
- Clk  in  1  system clock
- Rst_n  in  1  reset, asynchronous, active-low
- Req_valid  in  1  transaction request
- Req_ready  out  1  block accepts a request
- Req_rw  in  1  0 = register write, 1 = register read
- Req_slv  in  7  slave address
- Req_reg  in  8  register address
- Req_wdata  in  8  write data
- Rsp_valid  out  1  one-cycle completion pulse
- Rsp_err  out  2  00 ok, 01 NACK, 10 arbitration lost
- Rsp_rdata  out  8  read data
- Start, Stop, Read, Write  out  1 each  command bits CR[7:4] to the byte controller
- Tx_ack  out  1  master ACK bit in receive mode
- Txr  out  8  byte to load into the shift register
- Rxr  in  8  received byte from the shift register
- I2C_done  in  1  byte operation complete
- Rx_ack  in  1  slave ACK (0 = ACK)
- I2C_al  in  1  arbitration lost
- Busy  out  1  transaction in progress

Function
REQ-003 A request SHALL be accepted only on a cycle where Req_valid and Req_ready are both 1; all Req_* fields SHALL be latched on that cycle.
REQ-004 Req_ready SHALL be 1 only in IDLE; Busy SHALL equal ~Req_ready.
REQ-005 The FSM states SHALL be IDLE, ADDR_W, REG, WDATA, ADDR_R, RDATA, STOP_ERR and RESP.
REQ-006 Command bits and Txr SHALL be registered and asserted the cycle after state entry, and SHALL be held until the cycle after I2C_done, then cleared.
REQ-007 ADDR_W SHALL drive Start=1, Write=1, Txr={slv,0}.
- I2C_done with Rx_ack=0 -> REG.
REQ-008 REG SHALL drive Write=1, Txr=reg.
- I2C_done with Rx_ack=0 -> WDATA if rw=0, else ADDR_R.
REQ-009 WDATA SHALL drive Write=1, Stop=1, Txr=wdata.
- I2C_done -> RESP; err=01 if Rx_ack=1, else 00.
REQ-010 ADDR_R SHALL drive Start=1 (repeated start), Write=1, Txr={slv,1}.
- I2C_done with Rx_ack=0 -> RDATA.
REQ-011 RDATA SHALL drive Read=1, Stop=1, Tx_ack=1 (NACK on the last byte).
- I2C_done -> capture Rxr into Rsp_rdata -> RESP, err=00.
REQ-012 Rx_ack=1 at I2C_done in ADDR_W, REG or ADDR_R SHALL go to STOP_ERR.
- STOP_ERR drives Stop=1 only.
- I2C_done -> RESP, err=01.
REQ-013 I2C_al=1 in any non-IDLE state SHALL clear all command bits next cycle and go to RESP with err=10; no Stop is issued.
REQ-014 I2C_al SHALL take priority over a simultaneous I2C_done.
REQ-015 RESP SHALL pulse Rsp_valid for exactly one cycle, then return to IDLE; Req_ready SHALL rise the cycle after the pulse.
REQ-016 Rsp_rdata and Rsp_err SHALL hold their values until the next RESP.
- Rsp_rdata is 0x00 for writes and errors.
REQ-017 Req_valid while Busy SHALL be ignored and not queued.
REQ-018 I2C_done while IDLE or RESP SHALL be ignored.

Reset
REQ-019 On Rst_n=0, at any time including mid-transaction:
- the state SHALL go to IDLE;
- Start, Stop, Read, Write, Tx_ack, Rsp_valid SHALL be 0;
- Txr, Rsp_rdata, Rsp_err SHALL be 0;
- Req_ready SHALL be 1 and Busy 0;
- the retry counter SHALL be 0;
- no Stop SHALL be generated.

Configuration
REQ-020 With I2C_TXN_RETRY_EN defined, a NACK in ADDR_W SHALL pass through STOP_ERR and then re-enter ADDR_W instead of RESP, up to MAX_RETRY times.
- The 2-bit retry counter clears on accept.
- After the final retry fails, the block reports err=01.
REQ-021 Without I2C_TXN_RETRY_EN, an ADDR_W NACK SHALL behave as REQ-012, and the retry counter SHALL not exist.

Structure
REQ-022 State encodings (3-bit) and Rsp_err codes SHALL be `define constants in the shared header i2c_master_defines.v.
REQ-023 The block SHALL be a single module with no sub-modules; it instantiates neither the byte controller nor the bit controller.

Verification
REQ-024 Write slv=0x50, reg=0x10, data=0xA5, all ACK:
- Txr sequence 0xA0, 0x10, 0xA5;
- Stop asserted only with the third byte;
- one Rsp_valid with err=00.
REQ-025 Read slv=0x50, reg=0x20, Rxr=0x3C:
- Txr sequence 0xA0, 0x20, 0xA1;
- then Read+Stop with Tx_ack=1;
- Rsp_rdata=0x3C, err=00.
REQ-026 Rx_ack=1 on the REG byte:
- next command is Stop alone;
- after its I2C_done, err=01 and Rsp_rdata=0x00.
REQ-027 I2C_al=1 in the same cycle as I2C_done during WDATA:
- command bits are 0 next cycle;
- err=10; no Stop issued.
REQ-028 Rst_n low while in RDATA:
- all outputs are at reset values immediately;
- a new request after release is accepted on its first Req_valid cycle.
REQ-029 With I2C_TXN_RETRY_EN and MAX_RETRY=2, address always NACKed:
- exactly 3 Start+Write 0xA0 attempts, each followed by Stop;
- then err=01.
